// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) call scheduler for a small elevator.
// Latches hall-up, hall-down and car calls, times floor-to-floor travel and
// door dwell, and reports floor, motion state, direction and pending calls.
// Optional feature: define SCHED_FIRE_RECALL_EN to add the fire_recall input
// (cancel all calls, return to floor 0 and hold the door open).
module elevator_call_scheduler #(
    parameter int NUM_FLOORS   = 5,
    parameter int FLOOR_W      = 3,
    parameter int TRAVEL_TICKS = 50,
    parameter int DWELL_TICKS  = 250
) (
    input  logic                  clk_50hz,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [NUM_FLOORS-1:0] car_req,
`ifdef SCHED_FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    output logic [FLOOR_W-1:0]    floor,
    output logic [1:0]            state,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_dn,
    output logic [NUM_FLOORS-1:0] pend_car
);

    localparam int TCW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DCW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [TCW-1:0]        T_LAST = TCW'(TRAVEL_TICKS - 1);
    localparam logic [DCW-1:0]        D_LAST = DCW'(DWELL_TICKS - 1);
    localparam logic [FLOOR_W-1:0]    TOP    = FLOOR_W'(NUM_FLOORS - 1);
    // Up calls at the top floor and down calls at floor 0 are meaningless.
    localparam logic [NUM_FLOORS-1:0] UP_OK  = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
    localparam logic [NUM_FLOORS-1:0] DN_OK  = ~NUM_FLOORS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_DOOR = 2'b11
    } state_t;

    function automatic logic [NUM_FLOORS-1:0] sel_of(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) == f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
        return m;
    endfunction

    state_t                state_q, state_n;
    logic [FLOOR_W-1:0]    floor_q, floor_n;
    logic                  dir_q, dir_n;
    logic [TCW-1:0]        tcnt_q, tcnt_n;
    logic [DCW-1:0]        dcnt_q, dcnt_n;
    logic [NUM_FLOORS-1:0] pend_up_q, pend_dn_q, pend_car_q;
    logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
`ifdef SCHED_FIRE_RECALL_EN
    logic                  hold_q, hold_n;
`endif

    // Requests are accepted unless a fire recall is in progress.
    logic                  req_en;
`ifdef SCHED_FIRE_RECALL_EN
    assign req_en = ~fire_recall;
`else
    assign req_en = 1'b1;
`endif

    logic [NUM_FLOORS-1:0] req_up, req_dn, req_car;
    logic [NUM_FLOORS-1:0] eff_up, eff_dn, eff_car, all_calls;

    assign req_up  = hall_up & UP_OK & {NUM_FLOORS{req_en}};
    assign req_dn  = hall_dn & DN_OK & {NUM_FLOORS{req_en}};
    assign req_car = car_req & {NUM_FLOORS{req_en}};

    // Calls as seen this cycle: latched ones plus those arriving now, so a
    // request landing in the same cycle as a service is cleared with it.
    assign eff_up    = (pend_up_q  | req_up)  & {NUM_FLOORS{req_en}};
    assign eff_dn    = (pend_dn_q  | req_dn)  & {NUM_FLOORS{req_en}};
    assign eff_car   = (pend_car_q | req_car) & {NUM_FLOORS{req_en}};
    assign all_calls = eff_up | eff_dn | eff_car;

    logic [NUM_FLOORS-1:0] cur_sel, cur_above, cur_below;
    logic [NUM_FLOORS-1:0] nf_sel, nf_above, nf_below;
    logic [FLOOR_W-1:0]    nf;
    logic                  moving_up, stuck_end, arrive_end;
    logic                  beyond_nf, hall_fwd_nf, hall_rev_nf, stop_nf;
    logic                  ahead_fwd, ahead_rev, hall_rev_here, absorb;

    assign cur_sel   = sel_of(floor_q);
    assign cur_above = above_of(floor_q);
    assign cur_below = below_of(floor_q);

    assign moving_up  = (state_q == S_UP);
    assign stuck_end  = moving_up ? (floor_q == TOP) : (floor_q == '0);
    assign nf         = stuck_end ? floor_q
                      : (moving_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1));
    assign nf_sel     = sel_of(nf);
    assign nf_above   = above_of(nf);
    assign nf_below   = below_of(nf);
    assign arrive_end = moving_up ? (nf == TOP) : (nf == '0);

    assign beyond_nf   = moving_up ? |(all_calls & nf_above) : |(all_calls & nf_below);
    assign hall_fwd_nf = moving_up ? |(eff_up & nf_sel) : |(eff_dn & nf_sel);
    assign hall_rev_nf = moving_up ? |(eff_dn & nf_sel) : |(eff_up & nf_sel);
    assign stop_nf     = |(eff_car & nf_sel) | hall_fwd_nf
                       | (~beyond_nf & hall_rev_nf) | arrive_end;

    assign ahead_fwd     = dir_q ? |(all_calls & cur_above) : |(all_calls & cur_below);
    assign ahead_rev     = dir_q ? |(all_calls & cur_below) : |(all_calls & cur_above);
    assign hall_rev_here = dir_q ? |(eff_dn & cur_sel) : |(eff_up & cur_sel);
    assign absorb        = |((req_car | (dir_q ? req_up : req_dn)) & cur_sel);

    // Next-state, counter and call-clear decisions.
    always_comb begin
        state_n = state_q;
        floor_n = floor_q;
        dir_n   = dir_q;
        tcnt_n  = tcnt_q;
        dcnt_n  = dcnt_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;
`ifdef SCHED_FIRE_RECALL_EN
        hold_n  = hold_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|(all_calls & cur_sel)) begin
                    state_n = S_DOOR;
                    dcnt_n  = '0;
                    clr_up  = cur_sel;
                    clr_dn  = cur_sel;
                    clr_car = cur_sel;
                end else if (|(all_calls & cur_above)) begin
                    state_n = S_UP;
                    dir_n   = 1'b1;
                    tcnt_n  = '0;
                end else if (|(all_calls & cur_below)) begin
                    state_n = S_DOWN;
                    dir_n   = 1'b0;
                    tcnt_n  = '0;
                end
            end
            S_UP, S_DOWN: begin
                if (tcnt_q != T_LAST) begin
                    tcnt_n = tcnt_q + TCW'(1);
                end else begin
                    floor_n = nf;
                    tcnt_n  = '0;
                    if (stop_nf) begin
                        state_n = S_DOOR;
                        dcnt_n  = '0;
                        clr_car = nf_sel;
                        if (moving_up) begin
                            clr_up = nf_sel;
                            if (!beyond_nf) clr_dn = nf_sel;
                        end else begin
                            clr_dn = nf_sel;
                            if (!beyond_nf) clr_up = nf_sel;
                        end
                    end
                end
            end
            S_DOOR: begin
                if (absorb) begin
                    dcnt_n  = '0;
                    clr_car = cur_sel;
                    if (dir_q) clr_up = cur_sel;
                    else       clr_dn = cur_sel;
                end else if (dcnt_q != D_LAST) begin
                    dcnt_n = dcnt_q + DCW'(1);
                end else begin
                    dcnt_n = '0;
                    tcnt_n = '0;
                    if (ahead_fwd) begin
                        state_n = dir_q ? S_UP : S_DOWN;
                    end else if (ahead_rev) begin
                        dir_n = ~dir_q;
                        if (hall_rev_here) begin
                            state_n = S_DOOR;
                            if (dir_q) clr_dn = cur_sel;
                            else       clr_up = cur_sel;
                        end else begin
                            state_n = dir_q ? S_DOWN : S_UP;
                        end
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
        endcase
`ifdef SCHED_FIRE_RECALL_EN
        // Recall overrides normal scheduling: finish the current segment,
        // head down to floor 0 without stopping, then hold the door open.
        if (fire_recall) begin
            clr_up  = '0;
            clr_dn  = '0;
            clr_car = '0;
            dcnt_n  = '0;
            unique case (state_q)
                S_IDLE, S_DOOR: begin
                    if (floor_q == '0) begin
                        state_n = S_DOOR;
                        hold_n  = 1'b1;
                    end else begin
                        state_n = S_DOWN;
                        dir_n   = 1'b0;
                        tcnt_n  = '0;
                    end
                end
                S_UP, S_DOWN: begin
                    if (tcnt_q != T_LAST) begin
                        tcnt_n = tcnt_q + TCW'(1);
                    end else begin
                        floor_n = nf;
                        tcnt_n  = '0;
                        if (nf == '0) begin
                            state_n = S_DOOR;
                            hold_n  = 1'b1;
                        end else begin
                            state_n = S_DOWN;
                            dir_n   = 1'b0;
                        end
                    end
                end
            endcase
        end else if (hold_q) begin
            state_n = S_IDLE;
            hold_n  = 1'b0;
            dcnt_n  = '0;
            clr_up  = '0;
            clr_dn  = '0;
            clr_car = '0;
        end
`endif
    end

    // State, counters and latched calls; reset wins over everything.
    always_ff @(posedge clk_50hz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            pend_up_q  <= '0;
            pend_dn_q  <= '0;
            pend_car_q <= '0;
`ifdef SCHED_FIRE_RECALL_EN
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            floor_q    <= floor_n;
            dir_q      <= dir_n;
            tcnt_q     <= tcnt_n;
            dcnt_q     <= dcnt_n;
            pend_up_q  <= eff_up  & ~clr_up;
            pend_dn_q  <= eff_dn  & ~clr_dn;
            pend_car_q <= eff_car & ~clr_car;
`ifdef SCHED_FIRE_RECALL_EN
            hold_q     <= hold_n;
`endif
        end
    end

    assign floor     = floor_q;
    assign state     = state_q;
    assign dir_up    = dir_q;
    assign door_open = (state_q == S_DOOR);
    assign pend_up   = pend_up_q;
    assign pend_dn   = pend_dn_q;
    assign pend_car  = pend_car_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: directed scenarios followed
// by random call traffic, checked against a call-list reference model.
module tb_elevator_call_scheduler;

    localparam int NF = 5;
    localparam int FW = 3;
    localparam int TT = 4;
    localparam int DT = 6;

    logic          clk_50hz = 1'b0;
    logic          rst      = 1'b1;
    logic [NF-1:0] hall_up  = '0;
    logic [NF-1:0] hall_dn  = '0;
    logic [NF-1:0] car_req  = '0;
    logic [FW-1:0] floor;
    logic [1:0]    state;
    logic          dir_up;
    logic          door_open;
    logic [NF-1:0] pend_up;
    logic [NF-1:0] pend_dn;
    logic [NF-1:0] pend_car;

    always #5 clk_50hz = ~clk_50hz;

    elevator_call_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .TRAVEL_TICKS(TT),
        .DWELL_TICKS (DT)
    ) dut (
        .clk_50hz (clk_50hz),
        .rst      (rst),
        .hall_up  (hall_up),
        .hall_dn  (hall_dn),
        .car_req  (car_req),
        .floor    (floor),
        .state    (state),
        .dir_up   (dir_up),
        .door_open(door_open),
        .pend_up  (pend_up),
        .pend_dn  (pend_dn),
        .pend_car (pend_car)
    );

    typedef struct packed {
        logic [FW-1:0] fl;
        logic [1:0]    st;
        logic          dir;
        logic          door;
        logic [NF-1:0] pu;
        logic [NF-1:0] pd;
        logic [NF-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: lists of waiting calls per floor, position, mode
    // (0 idle, 1 going up, 2 going down, 3 door open), direction and the
    // number of cycles spent in the current travel segment or dwell.
    bit mu[NF];
    bit md[NF];
    bit mc[NF];
    int mfl;
    int mmode;
    bit mdir;
    int mel;

    function automatic bit calls_at(int f);
        return mu[f] || md[f] || mc[f];
    endfunction

    function automatic bit beyond(int f, bit up);
        for (int g = 0; g < NF; g++)
            if ((up ? (g > f) : (g < f)) && calls_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            mu[f] = 1'b0;
            md[f] = 1'b0;
            mc[f] = 1'b0;
        end
        mfl   = 0;
        mmode = 0;
        mdir  = 1'b1;
        mel   = 0;
    endtask

    task automatic model_step(input bit r, input logic [NF-1:0] hu, input logic [NF-1:0] hd,
                              input logic [NF-1:0] cr);
        int nf;
        bit stop;
        bit absorb;
        bit far;
        if (r) begin
            model_reset();
            return;
        end
        absorb = 1'b0;
        if (mmode == 3)
            absorb = cr[mfl] || (mdir ? (hu[mfl] && mfl != NF - 1) : (hd[mfl] && mfl != 0));
        for (int f = 0; f < NF; f++) begin
            if (cr[f]) mc[f] = 1'b1;
            if (hu[f] && f != NF - 1) mu[f] = 1'b1;
            if (hd[f] && f != 0) md[f] = 1'b1;
        end
        if (mmode == 0) begin
            if (calls_at(mfl)) begin
                mu[mfl] = 1'b0;
                md[mfl] = 1'b0;
                mc[mfl] = 1'b0;
                mmode   = 3;
                mel     = 0;
            end else if (beyond(mfl, 1'b1)) begin
                mmode = 1;
                mdir  = 1'b1;
                mel   = 0;
            end else if (beyond(mfl, 1'b0)) begin
                mmode = 2;
                mdir  = 1'b0;
                mel   = 0;
            end
        end else if (mmode == 1 || mmode == 2) begin
            mel++;
            if (mel == TT) begin
                mel = 0;
                nf  = mfl + ((mmode == 1) ? 1 : -1);
                if (nf < 0) nf = 0;
                if (nf > NF - 1) nf = NF - 1;
                mfl  = nf;
                far  = beyond(nf, mmode == 1);
                stop = mc[nf] || ((mmode == 1) ? mu[nf] : md[nf])
                    || (!far && ((mmode == 1) ? md[nf] : mu[nf]))
                    || nf == 0 || nf == NF - 1;
                if (stop) begin
                    mc[nf] = 1'b0;
                    if (mmode == 1) begin
                        mu[nf] = 1'b0;
                        if (!far) md[nf] = 1'b0;
                    end else begin
                        md[nf] = 1'b0;
                        if (!far) mu[nf] = 1'b0;
                    end
                    mmode = 3;
                end
            end
        end else begin
            if (absorb) begin
                mc[mfl] = 1'b0;
                if (mdir) mu[mfl] = 1'b0;
                else      md[mfl] = 1'b0;
                mel = 0;
            end else begin
                mel++;
                if (mel == DT) begin
                    mel = 0;
                    if (beyond(mfl, mdir)) begin
                        mmode = mdir ? 1 : 2;
                    end else if (beyond(mfl, !mdir)) begin
                        mdir = !mdir;
                        if (mdir ? mu[mfl] : md[mfl]) begin
                            if (mdir) mu[mfl] = 1'b0;
                            else      md[mfl] = 1'b0;
                        end else begin
                            mmode = mdir ? 1 : 2;
                        end
                    end else begin
                        mmode = 0;
                    end
                end
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.fl   = FW'(mfl);
        e.st   = 2'(mmode);
        e.dir  = mdir;
        e.door = (mmode == 3);
        for (int f = 0; f < NF; f++) begin
            e.pu[f] = mu[f];
            e.pd[f] = md[f];
            e.pc[f] = mc[f];
        end
        return e;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input logic r, input logic [NF-1:0] hu, input logic [NF-1:0] hd,
                       input logic [NF-1:0] cr);
        @(posedge clk_50hz);
        #2;
        rst     = r;
        hall_up = hu;
        hall_dn = hd;
        car_req = cr;
        model_step(r, hu, hd, cr);
        sb.push_back(snap());
    endtask

    task automatic quiet(input int n);
        repeat (n) cyc(1'b0, '0, '0, '0);
    endtask

    task automatic run_to_idle();
        int k;
        k = 0;
        while (mmode != 0 && k < 500) begin
            cyc(1'b0, '0, '0, '0);
            k++;
        end
    endtask

    task automatic run_to_moving_at(input int f);
        int k;
        k = 0;
        while (!(mfl == f && (mmode == 1 || mmode == 2)) && k < 500) begin
            cyc(1'b0, '0, '0, '0);
            k++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new snapshot one unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_50hz);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("floor", 32'(floor), 32'(e.fl));
                chk("state", 32'(state), 32'(e.st));
                chk("dir_up", 32'(dir_up), 32'(e.dir));
                chk("door_open", 32'(door_open), 32'(e.door));
                chk("pend", 32'({pend_up, pend_dn, pend_car}), 32'({e.pu, e.pd, e.pc}));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NF-1:0] hu, hd, cr;
        logic          r;
        model_reset();

        // Car call to floor 3 from reset.
        cyc(1'b1, '0, '0, '0);
        cyc(1'b0, '0, '0, 5'b01000);
        run_to_idle();
        quiet(2);

        // Hall-up at 2 while heading to 4: served on the way.
        cyc(1'b1, '0, '0, '0);
        cyc(1'b0, '0, '0, 5'b10000);
        run_to_moving_at(1);
        cyc(1'b0, 5'b00100, '0, '0);
        run_to_idle();

        // Hall-down at 2 while heading to 4: served on the way back.
        cyc(1'b1, '0, '0, '0);
        cyc(1'b0, '0, '0, 5'b10000);
        run_to_moving_at(1);
        cyc(1'b0, '0, 5'b00100, '0);
        run_to_idle();

        // Idle at 2, call at 2, repeat during the dwell.
        cyc(1'b0, '0, '0, 5'b00100);
        run_to_idle();
        cyc(1'b0, '0, '0, 5'b00100);
        quiet(3);
        cyc(1'b0, '0, '0, 5'b00100);
        run_to_idle();

        // Calls at both ends from floor 2, plus the two ignored hall buttons.
        cyc(1'b0, 5'b10000, 5'b00001, 5'b10001);
        run_to_idle();

        // Reset while travelling with calls pending.
        cyc(1'b1, '0, '0, '0);
        cyc(1'b0, 5'b00010, 5'b01000, 5'b10000);
        run_to_moving_at(1);
        cyc(1'b0, '0, '0, '0);
        cyc(1'b1, '0, '0, '0);
        quiet(3);

        // Random traffic, sparse then dense.
        for (int i = 0; i < 6000; i++) begin
            int p;
            p  = (i < 4500) ? 12 : 3;
            hu = ($urandom_range(0, p - 1) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
            hd = ($urandom_range(0, p - 1) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
            cr = ($urandom_range(0, p - 1) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
            r  = ($urandom_range(0, 1499) == 0);
            cyc(r, hu, hd, cr);
        end
        run_to_idle();

        @(posedge clk_50hz);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
